mem_access: RTL and testbench
=============================

# mem_access

Memory-access (ME) pipeline stage between EX and WB.
- Latches the EX result, performs loads and stores on a valid/ready data-memory bus, and formats load data (sign/zero extension, byte lanes).
- Presents the stage's destination register and data to ID for forwarding, and drives the register-file write port through the WB pipeline register.
- Raises a busy stall while a bus transaction is outstanding.

## Interface
Parameters:
- none; widths come from `WORD_W`, `ADDR_W`, `INSTR_W`, `REG_IDX_W`, `MEM_OP_W`, `DEST_SRC_W`.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- aresetn  in  1  reset, asynchronous and active-low.
- clr  in  1  synchronous clear of the captured entry; ignored while o_busy=1.
- i_pc, i_instr  in  ADDR_W, INSTR_W  EX-stage PC and instruction.
- i_alu_eval  in  WORD_W  ALU result: byte address for memory ops, result otherwise.
- i_store_data  in  WORD_W  rs2 value for stores.
- i_mem_op  in  MEM_OP_W  one of `MEM_OP_NONE/LB/LH/LW/LBU/LHU/SB/SH/SW`.
- i_dest_src  in  DEST_SRC_W  `DEST_SRC_NONE/ALU/MEM`.
- i_dest_reg  in  REG_IDX_W  destination register.
- o_pc, o_instr  out  ADDR_W, INSTR_W  captured PC and instruction.
- o_dest_reg, o_dest_src  out  REG_IDX_W, DEST_SRC_W  captured values, used by ID forwarding.
- o_dest_data  out  WORD_W  captured ALU result, or formatted load data for `DEST_SRC_MEM`.
- o_busy  out  1  stall request to the upstream stages.
- o_misaligned  out  1  the captured memory op is misaligned.
- o_dbus_valid  out  1  request valid.
- o_dbus_we  out  1  request is a write.
- o_dbus_addr  out  ADDR_W  word address, {addr[ADDR_W-1:2], 2'b00}.
- o_dbus_wdata  out  WORD_W  write data.
- o_dbus_strb  out  4  byte write strobes.
- i_dbus_ready  in  1  request accepted.
- i_dbus_rvalid  in  1  read data valid.
- i_dbus_rdata  in  WORD_W  read data.
- o_wb_dest_en  out  1  register-file write enable (registered).
- o_wb_dest_reg  out  REG_IDX_W  register-file write index (registered).
- o_wb_dest_data  out  WORD_W  register-file write data (registered).

## Operation
Capture:
- On each edge with o_busy=0, the stage captures all EX inputs.
- If clr=1 instead, the captured entry becomes a bubble: mem_op NONE, dest_src NONE, pc/instr 0.

FSM states:
- IDLE: the entry is complete.
- REQ: the request is presented on the bus.
- RESP: waiting for read data.

Transitions:
- On capture of an aligned memory op: next state REQ. Any other capture, including a misaligned memory op: IDLE.
- REQ: o_dbus_valid=1 with addr, we, wdata and strb held stable. When i_dbus_ready=1: a store goes to IDLE; a load goes to RESP.
- RESP: when i_dbus_rvalid=1, the formatted data is stored in the load-data register and the state goes to IDLE. i_dbus_rvalid is ignored in any other state.

Busy and forwarding:
- o_busy = (state != IDLE).
- o_dest_data is valid for forwarding only when o_busy=0.

Alignment:
- LH/LHU/SH require addr[0]=0; LW/SW require addr[1:0]=0.
- A misaligned op sets o_misaligned for the life of the entry and issues no bus access.
- A misaligned load writes nothing to the register file.

Store formatting:
- SB: strb = 4'b0001 << addr[1:0], wdata = {4{d[7:0]}}.
- SH: strb = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{d[15:0]}}.
- SW: strb = 4'b1111, wdata = d.

Load formatting (lane selected by the captured addr[1:0]):
- LB/LBU: rdata[8*addr[1:0] +: 8], sign-/zero-extended.
- LH/LHU: rdata[16*addr[1] +: 16], sign-/zero-extended.
- LW: rdata unchanged.

WB register:
- On each edge with o_busy=0: o_wb_dest_en = (dest_src != NONE) && !misaligned-load && dest_reg != 0; reg and data are copied from o_dest_reg and o_dest_data.
- On each edge with o_busy=1: o_wb_dest_en <= 0, i.e. a bubble.

## Timing
- Reset values (aresetn=0, immediate): state IDLE; all outputs 0; dest_src NONE; mem_op NONE. An in-flight request is abandoned and o_dbus_valid drops at once.
- ALU op: captured at edge N; o_wb_* updated at edge N+1.
- Store: valid at N; if ready=1 in the same cycle, o_busy falls after edge N+1; each cycle of ready=0 adds one cycle.
- Load: earliest completion has ready at cycle N and rvalid at cycle N+1. o_busy is high for 2 cycles, o_dest_data is valid in cycle N+2, and o_wb_* is updated at edge N+3.
- rvalid may be held low arbitrarily long; the stage waits with no timeout.
- clr asserted together with o_busy=1 is ignored, so the older in-flight op always completes.

## Test plan
- ALU forward: i_alu_eval=0x1234, dest_src ALU, rd=5 → next cycle o_dest_data=0x1234; following edge o_wb_dest_en=1, reg 5, data 0x1234.
- SB: addr=0x103, d=0xAB → o_dbus_strb=4'b1000, wdata=0xABABABAB, addr=0x100. With ready delayed 3 cycles, valid and all bus fields stay stable and o_busy=1 throughout.
- LB/LBU: addr=0x102, rdata=0x00F00000 → LB yields 0xFFFFFFF0, LBU yields 0x000000F0. With rvalid delayed 4 cycles, o_wb_dest_en stays 0 until completion.
- Misaligned LW at 0x106 → o_misaligned=1, no o_dbus_valid, o_busy=0, and the WB write is suppressed.
- clr during a pending load is ignored and the load completes. clr while idle produces a bubble with o_wb_dest_en=0.
- aresetn pulsed low in RESP → all outputs 0 immediately, state IDLE; a subsequent LW to 0x40 with rdata 0xDEADBEEF completes normally.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: ME pipeline stage with valid/ready data-bus loads/stores, load formatting, forwarding and WB register
package mem_access_pkg;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;
  localparam int INSTR_W = 32;
  localparam int REG_IDX_W = 5;
  localparam int MEM_OP_W = 4;
  localparam int DEST_SRC_W = 2;
  localparam logic [MEM_OP_W-1:0] MEM_OP_NONE = 4'd0;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LB = 4'd1;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LH = 4'd2;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LW = 4'd3;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LBU = 4'd4;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LHU = 4'd5;
  localparam logic [MEM_OP_W-1:0] MEM_OP_SB = 4'd6;
  localparam logic [MEM_OP_W-1:0] MEM_OP_SH = 4'd7;
  localparam logic [MEM_OP_W-1:0] MEM_OP_SW = 4'd8;
  localparam logic [DEST_SRC_W-1:0] DEST_SRC_NONE = 2'd0;
  localparam logic [DEST_SRC_W-1:0] DEST_SRC_ALU = 2'd1;
  localparam logic [DEST_SRC_W-1:0] DEST_SRC_MEM = 2'd2;
endpackage

module mem_access
  import mem_access_pkg::*;
(
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  clr,
  input  logic [ADDR_W-1:0]     i_pc,
  input  logic [INSTR_W-1:0]    i_instr,
  input  logic [WORD_W-1:0]     i_alu_eval,
  input  logic [WORD_W-1:0]     i_store_data,
  input  logic [MEM_OP_W-1:0]   i_mem_op,
  input  logic [DEST_SRC_W-1:0] i_dest_src,
  input  logic [REG_IDX_W-1:0]  i_dest_reg,
  output logic [ADDR_W-1:0]     o_pc,
  output logic [INSTR_W-1:0]    o_instr,
  output logic [REG_IDX_W-1:0]  o_dest_reg,
  output logic [DEST_SRC_W-1:0] o_dest_src,
  output logic [WORD_W-1:0]     o_dest_data,
  output logic                  o_busy,
  output logic                  o_misaligned,
  output logic                  o_dbus_valid,
  output logic                  o_dbus_we,
  output logic [ADDR_W-1:0]     o_dbus_addr,
  output logic [WORD_W-1:0]     o_dbus_wdata,
  output logic [3:0]            o_dbus_strb,
  input  logic                  i_dbus_ready,
  input  logic                  i_dbus_rvalid,
  input  logic [WORD_W-1:0]     i_dbus_rdata,
  output logic                  o_wb_dest_en,
  output logic [REG_IDX_W-1:0]  o_wb_dest_reg,
  output logic [WORD_W-1:0]     o_wb_dest_data
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic [WORD_W-1:0] alu_q, sd_q, ld_q, ld_fmt;
  logic [MEM_OP_W-1:0] op_q;
  logic [DEST_SRC_W-1:0] dsrc_q;
  logic [REG_IDX_W-1:0] dreg_q;
  logic mis_q, mis_in, go;
  logic [7:0] ld_b;
  logic [15:0] ld_h;

  function automatic logic is_ld(input logic [MEM_OP_W-1:0] op);
    return op inside {MEM_OP_LB, MEM_OP_LH, MEM_OP_LW, MEM_OP_LBU, MEM_OP_LHU};
  endfunction

  function automatic logic is_st(input logic [MEM_OP_W-1:0] op);
    return op inside {MEM_OP_SB, MEM_OP_SH, MEM_OP_SW};
  endfunction

  function automatic logic misal(input logic [MEM_OP_W-1:0] op, input logic [1:0] a);
    return ((op inside {MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH}) && a[0]) ||
           ((op inside {MEM_OP_LW, MEM_OP_SW}) && a != 2'b00);
  endfunction

  assign mis_in = misal(i_mem_op, i_alu_eval[1:0]);
  assign go = !clr && (is_ld(i_mem_op) || is_st(i_mem_op)) && !mis_in;

  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state == IDLE ? (go ? REQ : IDLE)
             : state == REQ  ? (i_dbus_ready ? (is_st(op_q) ? IDLE : RESP) : REQ)
             : (i_dbus_rvalid ? IDLE : RESP);
  end

  always_comb begin
    o_busy = state != IDLE;
    o_dbus_valid = state == REQ;
    o_dbus_we = is_st(op_q);
    o_dbus_addr = {alu_q[ADDR_W-1:2], 2'b00};
    o_dbus_strb = op_q == MEM_OP_SB ? 4'b0001 << alu_q[1:0]
                : op_q == MEM_OP_SH ? (alu_q[1] ? 4'b1100 : 4'b0011)
                : op_q == MEM_OP_SW ? 4'b1111 : 4'b0000;
    o_dbus_wdata = op_q == MEM_OP_SB ? {4{sd_q[7:0]}}
                 : op_q == MEM_OP_SH ? {2{sd_q[15:0]}} : sd_q;
  end

  always_comb begin
    ld_b = i_dbus_rdata[{alu_q[1:0], 3'b000} +: 8];
    ld_h = i_dbus_rdata[{alu_q[1], 4'b0000} +: 16];
    ld_fmt = op_q == MEM_OP_LB  ? {{24{ld_b[7]}}, ld_b}
           : op_q == MEM_OP_LBU ? {24'b0, ld_b}
           : op_q == MEM_OP_LH  ? {{16{ld_h[15]}}, ld_h}
           : op_q == MEM_OP_LHU ? {16'b0, ld_h} : i_dbus_rdata;
  end

  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) begin
      pc_q <= '0;
      instr_q <= '0;
      alu_q <= '0;
      sd_q <= '0;
      op_q <= MEM_OP_NONE;
      dsrc_q <= DEST_SRC_NONE;
      dreg_q <= '0;
      mis_q <= 1'b0;
    end else if (!o_busy) begin
      pc_q <= clr ? '0 : i_pc;
      instr_q <= clr ? '0 : i_instr;
      alu_q <= clr ? '0 : i_alu_eval;
      sd_q <= clr ? '0 : i_store_data;
      op_q <= clr ? MEM_OP_NONE : i_mem_op;
      dsrc_q <= clr ? DEST_SRC_NONE : i_dest_src;
      dreg_q <= clr ? '0 : i_dest_reg;
      mis_q <= !clr && mis_in;
    end

  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) ld_q <= '0;
    else if (state == RESP && i_dbus_rvalid) ld_q <= ld_fmt;

  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) begin
      o_wb_dest_en <= 1'b0;
      o_wb_dest_reg <= '0;
      o_wb_dest_data <= '0;
    end else if (o_busy) o_wb_dest_en <= 1'b0;
    else begin
      o_wb_dest_en <= dsrc_q != DEST_SRC_NONE && !(mis_q && is_ld(op_q)) && dreg_q != '0;
      o_wb_dest_reg <= dreg_q;
      o_wb_dest_data <= o_dest_data;
    end

  assign o_pc = pc_q;
  assign o_instr = instr_q;
  assign o_dest_reg = dreg_q;
  assign o_dest_src = dsrc_q;
  assign o_dest_data = dsrc_q == DEST_SRC_MEM ? ld_q : alu_q;
  assign o_misaligned = mis_q;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized scoreboard bench for mem_access against a byte-addressed memory model
module tb_mem_access;
  import mem_access_pkg::*;
  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic clr = 1'b0;
  logic [31:0] i_pc = '0, i_instr = '0, i_alu_eval = '0, i_store_data = '0;
  logic [3:0] i_mem_op = MEM_OP_NONE;
  logic [1:0] i_dest_src = DEST_SRC_NONE;
  logic [4:0] i_dest_reg = '0;
  logic [31:0] o_pc, o_instr, o_dest_data, o_dbus_addr, o_dbus_wdata, o_wb_dest_data;
  logic [4:0] o_dest_reg, o_wb_dest_reg;
  logic [1:0] o_dest_src;
  logic o_busy, o_misaligned, o_dbus_valid, o_dbus_we, o_wb_dest_en;
  logic [3:0] o_dbus_strb;
  logic i_dbus_ready = 1'b0, i_dbus_rvalid = 1'b0;
  logic [31:0] i_dbus_rdata = '0;

  mem_access dut (
    .clk(clk), .aresetn(aresetn), .clr(clr),
    .i_pc(i_pc), .i_instr(i_instr), .i_alu_eval(i_alu_eval), .i_store_data(i_store_data),
    .i_mem_op(i_mem_op), .i_dest_src(i_dest_src), .i_dest_reg(i_dest_reg),
    .o_pc(o_pc), .o_instr(o_instr), .o_dest_reg(o_dest_reg), .o_dest_src(o_dest_src),
    .o_dest_data(o_dest_data), .o_busy(o_busy), .o_misaligned(o_misaligned),
    .o_dbus_valid(o_dbus_valid), .o_dbus_we(o_dbus_we), .o_dbus_addr(o_dbus_addr),
    .o_dbus_wdata(o_dbus_wdata), .o_dbus_strb(o_dbus_strb), .i_dbus_ready(i_dbus_ready),
    .i_dbus_rvalid(i_dbus_rvalid), .i_dbus_rdata(i_dbus_rdata),
    .o_wb_dest_en(o_wb_dest_en), .o_wb_dest_reg(o_wb_dest_reg), .o_wb_dest_data(o_wb_dest_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {logic [4:0] rd; logic [31:0] d;} wb_t;
  typedef struct {logic [31:0] a; logic we; logic [31:0] wd; logic [3:0] st;} bus_t;
  wb_t exp_wb[$];
  bus_t exp_bus[$];
  logic [7:0] rbyte [int unsigned];
  logic [31:0] smem [int unsigned];

  function automatic logic [31:0] winit(input logic [31:0] w);
    return (w * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  function automatic logic [7:0] rb(input logic [31:0] a);
    logic [31:0] w;
    w = winit(a >> 2) >> (8 * (a % 4));
    return rbyte.exists(a) ? rbyte[a] : w[7:0];
  endfunction

  int rq_cnt = 0, rd_cnt = 0, force_rd = -1, busy_clr = 0;
  logic rd_pend = 1'b0, hold = 1'b0;
  int unsigned rd_addr = 0;

  initial forever begin
    int unsigned w;
    @(posedge clk);
    #1;
    i_dbus_ready = 1'b0;
    i_dbus_rvalid = ($urandom % 4) == 0;
    i_dbus_rdata = $urandom;
    if (!aresetn) begin
      rd_pend = 1'b0;
      i_dbus_rvalid = 1'b0;
    end else if (rd_pend) begin
      i_dbus_rvalid = 1'b0;
      if (hold) ;
      else if (rd_cnt > 0) rd_cnt--;
      else begin
        i_dbus_rvalid = 1'b1;
        i_dbus_rdata = smem.exists(rd_addr) ? smem[rd_addr] : winit(rd_addr);
        rd_pend = 1'b0;
      end
    end else if (o_dbus_valid) begin
      if (rq_cnt > 0) rq_cnt--;
      else begin
        i_dbus_ready = 1'b1;
        w = o_dbus_addr >> 2;
        if (o_dbus_we) begin
          if (!smem.exists(w)) smem[w] = winit(w);
          for (int i = 0; i < 4; i++)
            if (o_dbus_strb[i]) smem[w][8*i +: 8] = o_dbus_wdata[8*i +: 8];
        end else begin
          rd_pend = 1'b1;
          rd_addr = w;
          rd_cnt = force_rd >= 0 ? force_rd : $urandom_range(0, 4);
          force_rd = -1;
        end
        rq_cnt = $urandom_range(0, 3);
      end
    end
  end

  initial forever begin
    bus_t b;
    wb_t e;
    @(negedge clk);
    if (o_dbus_valid && i_dbus_ready) begin
      if (exp_bus.size() == 0) check("bus_unexpected", 1, 0);
      else begin
        b = exp_bus.pop_front();
        check("bus_req", {o_dbus_addr, o_dbus_we, b.we ? {o_dbus_wdata, o_dbus_strb} : 36'b0},
                         {b.a, b.we, b.we ? {b.wd, b.st} : 36'b0});
      end
    end
    if (o_wb_dest_en) begin
      if (exp_wb.size() == 0) check("wb_unexpected", {o_wb_dest_reg, o_wb_dest_data}, 0);
      else begin
        e = exp_wb.pop_front();
        check("wb_write", {o_wb_dest_reg, o_wb_dest_data}, {e.rd, e.d});
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [1:0] ds, input logic [4:0] rd,
                       input logic [31:0] v, input logic [31:0] sd, input logic c);
    int n = 0, sz;
    logic ld, stv;
    logic [31:0] val, wd;
    logic [3:0] st;
    @(negedge clk);
    while (o_busy && n < 200) begin
      clr = busy_clr == 1 ? 1'b1 : busy_clr == 2 ? 1'($urandom % 2) : 1'b0;
      @(negedge clk);
      n++;
    end
    if (o_busy) check("busy_timeout", 1, 0);
    i_pc = $urandom; i_instr = $urandom; i_alu_eval = v; i_store_data = sd;
    i_mem_op = op; i_dest_src = ds; i_dest_reg = rd; clr = c;
    if (!c) begin
      sz = (op inside {MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB}) ? 1 : (op inside {MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH}) ? 2 : 4;
      ld = op inside {MEM_OP_LB, MEM_OP_LH, MEM_OP_LW, MEM_OP_LBU, MEM_OP_LHU};
      stv = op inside {MEM_OP_SB, MEM_OP_SH, MEM_OP_SW};
      if ((ld || stv) && (v % sz) == 0) begin
        if (stv) begin
          st = '0;
          for (int i = 0; i < sz; i++) begin
            st[(v + i) % 4] = 1'b1;
            val = sd >> (8 * i);
            rbyte[v + i] = val[7:0];
          end
          wd = sz == 1 ? {24'b0, sd[7:0]} * 32'h01010101 : sz == 2 ? {16'b0, sd[15:0]} * 32'h00010001 : sd;
          exp_bus.push_back('{v & ~32'd3, 1'b1, wd, st});
        end else begin
          exp_bus.push_back('{v & ~32'd3, 1'b0, 32'd0, 4'd0});
          val = '0;
          for (int i = 0; i < sz; i++) val |= {24'b0, rb(v + i)} << (8 * i);
          if ((op == MEM_OP_LB || op == MEM_OP_LH) && val[8*sz-1]) val |= 32'hFFFFFFFF << (8 * sz);
          if (rd != 0) exp_wb.push_back('{rd, val});
        end
      end else if (ds == DEST_SRC_ALU && rd != 0) exp_wb.push_back('{rd, v});
    end
    @(posedge clk);
    #1;
    i_mem_op = MEM_OP_NONE; i_dest_src = DEST_SRC_NONE; clr = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic watch_wb);
    for (int i = 0; i < 60 && o_busy; i++) begin
      if (watch_wb) check({name, "_wb_held"}, o_wb_dest_en, 0);
      @(negedge clk);
    end
    check({name, "_done"}, o_busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    int r, sz;
    logic [3:0] op;
    logic [31:0] a;
    #12;
    check("reset_outputs", {o_busy, o_dbus_valid, o_wb_dest_en, o_misaligned, o_dest_src, o_dest_data, o_dbus_strb, o_pc},
                           0);
    @(negedge clk);
    aresetn = 1'b1;
    issue(MEM_OP_NONE, DEST_SRC_ALU, 5'd5, 32'h1234, 0, 0);
    check("alu_forward", {o_dest_reg, o_dest_data, o_busy}, {5'd5, 32'h1234, 1'b0});
    rq_cnt = 3;
    issue(MEM_OP_SB, DEST_SRC_NONE, 5'd0, 32'h103, 32'hAB, 0);
    for (int i = 0; i < 4; i++) begin
      check("sb_stall", {o_dbus_valid, o_busy, o_dbus_addr, o_dbus_strb, o_dbus_wdata},
                        {1'b1, 1'b1, 32'h100, 4'b1000, 32'hABABABAB});
      @(posedge clk);
      #1;
    end
    issue(MEM_OP_SW, DEST_SRC_NONE, 5'd0, 32'h100, 32'h00F00000, 0);
    force_rd = 4;
    issue(MEM_OP_LB, DEST_SRC_MEM, 5'd6, 32'h102, 0, 0);
    wait_done("lb", 1);
    check("lb_data", o_dest_data, 32'hFFFFFFF0);
    force_rd = 4;
    issue(MEM_OP_LBU, DEST_SRC_MEM, 5'd7, 32'h102, 0, 0);
    wait_done("lbu", 1);
    check("lbu_data", o_dest_data, 32'h000000F0);
    issue(MEM_OP_LW, DEST_SRC_MEM, 5'd8, 32'h106, 0, 0);
    check("misaligned_lw", {o_misaligned, o_busy, o_dbus_valid}, 3'b100);
    busy_clr = 1;
    force_rd = 3;
    issue(MEM_OP_LW, DEST_SRC_MEM, 5'd9, 32'h100, 0, 0);
    issue(MEM_OP_NONE, DEST_SRC_ALU, 5'd10, 32'h55, 0, 1);
    busy_clr = 0;
    check("clr_bubble", {o_dest_src, o_pc, o_dest_reg}, 0);
    @(posedge clk);
    #1;
    check("clr_bubble_wb", o_wb_dest_en, 0);
    issue(MEM_OP_SW, DEST_SRC_NONE, 5'd0, 32'h40, 32'hDEADBEEF, 0);
    hold = 1'b1;
    issue(MEM_OP_LW, DEST_SRC_MEM, 5'd11, 32'h40, 0, 0);
    for (int i = 0; i < 20 && !(o_busy && !o_dbus_valid); i++) @(negedge clk);
    check("resp_reached", {o_busy, o_dbus_valid}, 2'b10);
    #2;
    aresetn = 1'b0;
    #1;
    check("async_reset", {o_busy, o_dbus_valid, o_wb_dest_en, o_misaligned, o_dest_src, o_dest_data, o_dbus_addr, o_pc},
                         0);
    exp_wb.delete();
    @(posedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    hold = 1'b0;
    issue(MEM_OP_LW, DEST_SRC_MEM, 5'd11, 32'h40, 0, 0);
    wait_done("lw_after_reset", 0);
    check("lw_after_reset_data", o_dest_data, 32'hDEADBEEF);
    busy_clr = 2;
    for (int k = 0; k < 300; k++) begin
      r = $urandom % 10;
      op = r < 4 ? MEM_OP_NONE : r < 7 ? 4'($urandom_range(1, 5)) : 4'($urandom_range(6, 8));
      sz = (op inside {MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB}) ? 1 : (op inside {MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH}) ? 2 : 4;
      a = $urandom_range(0, 255);
      if ($urandom % 4 != 0) a = a & ~(sz - 1);
      issue(op, r < 3 ? DEST_SRC_ALU : r < 4 ? DEST_SRC_NONE : r < 7 ? DEST_SRC_MEM : DEST_SRC_NONE,
            5'($urandom), r < 4 ? $urandom : a, $urandom, ($urandom % 10) == 0);
    end
    busy_clr = 0;
    @(negedge clk);
    for (int i = 0; i < 60 && o_busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("drain_wb", exp_wb.size(), 0);
    check("drain_bus", exp_bus.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
